// File: rtl/bcd_step_counter.sv
// Two-digit BCD up/down step counter: synchronizes a raw pushbutton and two switches,
// debounces the key, and steps the ones/tens digits once per accepted press.
module bcd_step_counter #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 19
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_STEP,
    input  logic       SW_DIR,
    input  logic       SW_CLR,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic       WRAP,
    output logic       PRESSED
);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
    // Key idles high (released), switches idle low.
    localparam logic [2:0]      SYNC_RST = 3'b001;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_PEND,
        S_HELD,
        S_RELEASE_PEND
    } db_state_t;

    logic [2:0] raw_in;
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic       ks;
    logic       dir;
    logic       clr;

    assign raw_in = {SW_CLR, SW_DIR, KEY_STEP};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    meta_q[gi] <= SYNC_RST[gi];
                    sync_q[gi] <= SYNC_RST[gi];
                end else begin
                    meta_q[gi] <= raw_in[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign ks  = sync_q[0];
    assign dir = sync_q[1];
    assign clr = sync_q[2];

    db_state_t       state_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            step_q;
    logic            pressed_q;

    // A press is accepted only after DB_CYCLES consecutive low samples; the step
    // pulse is issued once, on the transition into HELD.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_RELEASED;
            db_cnt_q  <= '0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                S_RELEASED: begin
                    if (!ks) begin
                        state_q  <= S_PRESS_PEND;
                        db_cnt_q <= '0;
                    end
                end
                S_PRESS_PEND: begin
                    if (ks) begin
                        state_q <= S_RELEASED;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= S_HELD;
                        step_q    <= 1'b1;
                        pressed_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                S_HELD: begin
                    if (ks) begin
                        state_q  <= S_RELEASE_PEND;
                        db_cnt_q <= '0;
                    end
                end
                S_RELEASE_PEND: begin
                    if (!ks) begin
                        state_q <= S_HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= S_RELEASED;
                        pressed_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_q   <= S_RELEASED;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    logic [3:0] dig0_q, dig0_d;
    logic [3:0] dig1_q, dig1_d;
    logic       wrap_q, wrap_d;

    // Clear outranks a step, so a step landing during clear is simply dropped.
    always_comb begin
        dig0_d = dig0_q;
        dig1_d = dig1_q;
        wrap_d = 1'b0;
        if (clr) begin
            dig0_d = 4'd0;
            dig1_d = 4'd0;
        end else if (step_q && dir) begin
            if (dig0_q == 4'd9) begin
                dig0_d = 4'd0;
                if (dig1_q == 4'd9) begin
                    dig1_d = 4'd0;
                    wrap_d = 1'b1;
                end else begin
                    dig1_d = dig1_q + 4'd1;
                end
            end else begin
                dig0_d = dig0_q + 4'd1;
            end
        end else if (step_q) begin
            if (dig0_q == 4'd0) begin
                dig0_d = 4'd9;
                if (dig1_q == 4'd0) begin
                    dig1_d = 4'd9;
                    wrap_d = 1'b1;
                end else begin
                    dig1_d = dig1_q - 4'd1;
                end
            end else begin
                dig0_d = dig0_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dig0_q <= 4'd0;
            dig1_q <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            dig0_q <= dig0_d;
            dig1_q <= dig1_d;
            wrap_q <= wrap_d;
        end
    end

    assign DIG0    = dig0_q;
    assign DIG1    = dig1_q;
    assign WRAP    = wrap_q;
    assign PRESSED = pressed_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Scoreboard bench for bcd_step_counter with a short debounce (DB_CYCLES=4).
module tb_bcd_step_counter;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       KEY_STEP = 1'b1;
    logic       SW_DIR   = 1'b1;
    logic       SW_CLR   = 1'b0;
    logic [3:0] DIG0;
    logic [3:0] DIG1;
    logic       WRAP;
    logic       PRESSED;

    bcd_step_counter #(.DB_CYCLES(4), .DB_W(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_STEP (KEY_STEP),
        .SW_DIR   (SW_DIR),
        .SW_CLR   (SW_CLR),
        .DIG0     (DIG0),
        .DIG1     (DIG1),
        .WRAP     (WRAP),
        .PRESSED  (PRESSED)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] bcd;
        logic       wrap;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model  = 0;

    // Monitor: every change of the digit/wrap outputs must match the next expectation.
    initial begin
        logic [8:0] prev;
        logic [8:0] cur;
        exp_t       e;
        prev = 9'h0;
        forever begin
            @(negedge CLOCK_50);
            cur = {DIG1, DIG0, WRAP};
            if (!RESET_N) begin
                prev = cur;
            end else if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h wrap=%b at cycle %0d, required no change",
                             cur[8:1], cur[0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== {e.bcd, e.wrap} || cyc != e.at) begin
                        errors++;
                        $display("FAIL output_event: got %h wrap=%b at cycle %0d, required %h wrap=%b at cycle %0d",
                                 cur[8:1], cur[0], cyc, e.bcd, e.wrap, e.at);
                    end else begin
                        $display("event ok: %h wrap=%b at cycle %0d", e.bcd, e.wrap, e.at);
                    end
                end
                prev = cur;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    // Advance the model by one step and queue the resulting output event(s).
    task automatic expect_step(input logic up, input int at);
        logic w;
        w = 1'b0;
        if (up) begin
            if (model == 99) begin model = 0; w = 1'b1; end
            else model++;
        end else begin
            if (model == 0) begin model = 99; w = 1'b1; end
            else model--;
        end
        exp_q.push_back('{to_bcd(model), w, at});
        if (w) exp_q.push_back('{to_bcd(model), 1'b0, at + 1});
    endtask

    task automatic press(input logic up, input bit discard);
        int c;
        @(posedge CLOCK_50); #1;
        SW_DIR   = up;
        KEY_STEP = 1'b0;
        c = cyc;
        if (!discard) expect_step(up, c + 8);
        repeat (20) @(posedge CLOCK_50);
        #1 KEY_STEP = 1'b1;
        repeat (12) @(posedge CLOCK_50);
    endtask

    initial begin
        int  c;
        bit  seen;

        // Reset state
        #1;
        chk("reset_dig", int'({DIG1, DIG0}), 'h00);
        chk("reset_wrap", int'(WRAP), 0);
        chk("reset_pressed", int'(PRESSED), 0);
        repeat (3) @(posedge CLOCK_50);
        #1 RESET_N = 1'b1;
        repeat (3) @(posedge CLOCK_50);

        // Single press with latency check, and PRESSED while held
        @(posedge CLOCK_50); #1;
        SW_DIR   = 1'b1;
        KEY_STEP = 1'b0;
        c = cyc;
        expect_step(1'b1, c + 8);
        repeat (12) @(posedge CLOCK_50);
        #1 chk("pressed_held", int'(PRESSED), 1);
        repeat (8) @(posedge CLOCK_50);
        #1 KEY_STEP = 1'b1;
        repeat (12) @(posedge CLOCK_50);
        #1 chk("single_press", int'({DIG1, DIG0}), 'h01);
        chk("pressed_released", int'(PRESSED), 0);

        // Bounce: low 3, high 2, low 3
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_50); #1;
            KEY_STEP = !(i < 3 || (i >= 5 && i < 8));
            @(negedge CLOCK_50);
            if (PRESSED) seen = 1'b1;
        end
        chk("bounce_pressed", int'(seen), 0);
        chk("bounce_count", int'({DIG1, DIG0}), 'h01);

        // Carry up
        repeat (8) press(1'b1, 1'b0);
        chk("count_09", int'({DIG1, DIG0}), 'h09);
        press(1'b1, 1'b0);
        chk("carry_10", int'({DIG1, DIG0}), 'h10);
        chk("carry_wrap", int'(WRAP), 0);

        // Async reset at 37 mid-press, then re-debounce of the still-held key
        repeat (27) press(1'b1, 1'b0);
        chk("count_37", int'({DIG1, DIG0}), 'h37);
        @(posedge CLOCK_50); #1;
        KEY_STEP = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_dig", int'({DIG1, DIG0}), 'h00);
        chk("async_rst_wrap", int'(WRAP), 0);
        chk("async_rst_pressed", int'(PRESSED), 0);
        model = 0;
        repeat (3) @(posedge CLOCK_50);
        #1 RESET_N = 1'b1;
        c = cyc;
        expect_step(1'b1, c + 8);
        repeat (12) @(posedge CLOCK_50);
        #1 chk("rst_redebounce_pressed", int'(PRESSED), 1);
        repeat (20) @(posedge CLOCK_50);
        #1 KEY_STEP = 1'b1;
        repeat (12) @(posedge CLOCK_50);
        #1 chk("rst_redebounce_count", int'({DIG1, DIG0}), 'h01);

        // Borrow/wrap down, then wrap up
        press(1'b0, 1'b0);
        press(1'b0, 1'b0);
        chk("wrap_down_99", int'({DIG1, DIG0}), 'h99);
        press(1'b1, 1'b0);
        chk("wrap_up_00", int'({DIG1, DIG0}), 'h00);
        repeat (10) press(1'b1, 1'b0);
        press(1'b0, 1'b0);
        chk("borrow_09", int'({DIG1, DIG0}), 'h09);

        // Clear priority over a completing press
        repeat (33) press(1'b1, 1'b0);
        chk("count_42", int'({DIG1, DIG0}), 'h42);
        @(posedge CLOCK_50); #1;
        SW_CLR = 1'b1;
        c = cyc;
        model = 0;
        exp_q.push_back('{8'h00, 1'b0, c + 3});
        repeat (5) @(posedge CLOCK_50);
        press(1'b1, 1'b1);
        chk("clear_discard", int'({DIG1, DIG0}), 'h00);
        @(posedge CLOCK_50); #1 SW_CLR = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        press(1'b1, 1'b0);
        chk("after_clear_01", int'({DIG1, DIG0}), 'h01);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLOCK_50);
        #1 chk("pending_events", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_step_counter.md
Name: bcd_step_counter

Overview:
- Two-digit BCD up/down counter driven by a raw board pushbutton and two slide switches.
- Sits directly upstream of the two-digit seg7 display stage. DIG0 feeds the SW0 nibble (ones), DIG1 feeds the SW1 nibble (tens).
- Contains an input synchronizer, a debounce state machine, press-edge detection and the BCD count datapath.
- Guarantees the display stage only ever receives digit values 0-9.

Parameters:
- DB_CYCLES, 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); must be >= 1.
- DB_W, 19, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- RESET_N  input  1  reset, asynchronous assert, active-low.
- KEY_STEP  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLOCK_50.
- SW_DIR  input  1  count direction: 1 = up, 0 = down; asynchronous.
- SW_CLR  input  1  clear request, active-high level; asynchronous.
- DIG0  output  4  ones digit, BCD 0-9.
- DIG1  output  4  tens digit, BCD 0-9.
- WRAP  output  1  one-cycle pulse when the count wraps (99->00 up, 00->99 down).
- PRESSED  output  1  debounced key state, 1 while the key is accepted as held.

Behaviour:
- One clock, CLOCK_50. Reset is asynchronous and active-low on RESET_N.
- While RESET_N=0, all state clears immediately:
  - DIG0=0, DIG1=0, WRAP=0, PRESSED=0;
  - synchronizer flops =1 for KEY_STEP, =0 for SW_DIR and SW_CLR;
  - debounce FSM in RELEASED, debounce counter=0.
- Deassertion of RESET_N mid-press: the key is treated as released and must be re-debounced. A held key produces exactly one step, after the full debounce delay.
- Synchronizer: KEY_STEP, SW_DIR and SW_CLR each pass through a 2-flop synchronizer. Only synchronized versions (ks, dir, clr) are used below.
- Debounce FSM states: RELEASED, PRESS_PEND, HELD, RELEASE_PEND.
  - RELEASED: ks=0 -> PRESS_PEND, counter cleared to 0.
  - PRESS_PEND: ks=1 -> RELEASED (glitch rejected). Otherwise counter increments. When counter reaches DB_CYCLES-1 with ks still 0 -> HELD, and assert step for exactly that one cycle.
  - HELD: ks=1 -> RELEASE_PEND, counter cleared.
  - RELEASE_PEND: ks=0 -> HELD. Counter reaching DB_CYCLES-1 with ks=1 -> RELEASED; no event on release.
  - PRESSED=1 in HELD and RELEASE_PEND, 0 otherwise (registered state decode).
- Latency: with KEY_STEP held low from cycle 0, the digits update exactly DB_CYCLES+4 cycles later. One step per debounced press, regardless of hold duration.
- Count update (registered, on the cycle after step), priority top-down:
  1. clr=1: DIG1:DIG0 <= 00 and WRAP=0. Steps arriving while clr=1 are discarded, not queued.
  2. step with dir=1:
     - DIG0=9 -> DIG0<=0 and DIG1 increments.
     - DIG1=9 and DIG0=9 -> 00 with WRAP=1.
     - otherwise DIG0 increments.
  3. step with dir=0:
     - DIG0=0 -> DIG0<=9 and DIG1 decrements.
     - 00 -> 99 with WRAP=1.
     - otherwise DIG0 decrements.
  4. Otherwise: hold; WRAP=0.
- dir is sampled in the step cycle. A direction change during debounce affects only that pending step.
- WRAP is high for exactly one cycle, coincident with the wrapped digit values.
- Digits never leave 0-9; no binary-to-BCD conversion.

Test Plan (DB_CYCLES overridden to 4, DB_W=3):
- Reset: assert RESET_N=0 mid-count at 37 -> DIG1=0, DIG0=0, WRAP=0, PRESSED=0 immediately, without waiting for a clock edge.
- Single press: SW_DIR=1, KEY_STEP low for 20 cycles from 00 -> DIG0=1 exactly 8 cycles after KEY_STEP falls, PRESSED=1, no further change while held.
- Bounce rejection: KEY_STEP pulses low 3 cycles, high 2, low 3 -> count unchanged, PRESSED stays 0.
- Carry and wrap up: from 09 one press -> 10, WRAP=0. From 99 one press -> 00 with WRAP=1 for one cycle.
- Borrow and wrap down: SW_DIR=0, from 10 one press -> 09. From 00 one press -> 99 with WRAP=1 for one cycle.
- Clear priority: count 42, SW_CLR=1 held while a press completes debounce -> 00, step discarded. After SW_CLR=0, the next press gives 01.
